// File: rtl/kd_tree_ctrl.sv
// Host-side sequencer for a KD-tree of sort nodes: resets the tree, streams
// centers into the root node, then launches the sort and waits for completion.
module kd_tree_ctrl #(
    parameter int COMMAND_SIZE = 5,
    parameter int DATA_SIZE    = 24,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic                    center_valid,
    input  logic [DATA_SIZE-1:0]    center_data,
    output logic                    center_ready,
    output logic [COMMAND_SIZE-1:0] cmd_to_root,
    output logic [DATA_SIZE-1:0]    data_to_root,
    input  logic [COMMAND_SIZE-1:0] cmd_from_root,
    output logic [CNT_W-1:0]        centers_loaded
);

    localparam logic [COMMAND_SIZE-1:0] CMD_NOP          = COMMAND_SIZE'(5'h00);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST          = COMMAND_SIZE'(5'h1f);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE     = COMMAND_SIZE'(5'h1e);
    localparam logic [COMMAND_SIZE-1:0] CMD_FILL         = COMMAND_SIZE'(5'h01);
    localparam logic [COMMAND_SIZE-1:0] CMD_FILL_DONE    = COMMAND_SIZE'(5'h05);
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORT   = COMMAND_SIZE'(5'h09);
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT   = COMMAND_SIZE'(5'h0f);
    localparam logic [CNT_W-1:0]        PHASE_LAST       = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TREE_RST,
        S_FILL,
        S_SORT_START,
        S_SORT_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q;
    logic [COMMAND_SIZE-1:0] cmd_q;
    logic [DATA_SIZE-1:0]    data_q;
    logic                    done_q;
    logic                    error_q;
    logic [CNT_W-1:0]        loaded_q;
    logic [CNT_W-1:0]        phase_q;

    logic                    fill_done;
    logic                    transfer;
    logic                    phase_expired;
    logic [CNT_W-1:0]        phase_d;
    logic [CNT_W-1:0]        loaded_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign fill_done     = (cmd_from_root == CMD_FILL_DONE);
    assign center_ready  = (state_q == S_FILL) && !fill_done;
    assign transfer      = center_valid && center_ready;
    assign phase_expired = (phase_q == PHASE_LAST);
    assign phase_d       = phase_q + CNT_W'(1);
    assign loaded_d      = sat_inc(loaded_q);

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign error          = error_q;
    assign cmd_to_root    = cmd_q;
    assign data_to_root   = data_q;
    assign centers_loaded = loaded_q;

    // Exit conditions are tested before the timeout so a same-cycle exit wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_NOP;
            data_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            loaded_q <= '0;
            phase_q  <= '0;
        end else begin
            done_q <= 1'b0;
            cmd_q  <= CMD_NOP;
            case (state_q)
                S_IDLE: begin
                    data_q <= '0;
                    if (start) begin
                        state_q  <= S_TREE_RST;
                        cmd_q    <= CMD_RST;
                        error_q  <= 1'b0;
                        loaded_q <= '0;
                        phase_q  <= '0;
                    end
                end
                S_TREE_RST: begin
                    if (cmd_from_root == CMD_RST_DONE) begin
                        state_q <= S_FILL;
                        phase_q <= '0;
                    end else if (phase_expired) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        cmd_q   <= CMD_RST;
                        phase_q <= phase_d;
                    end
                end
                S_FILL: begin
                    if (fill_done) begin
                        state_q <= S_SORT_START;
                        cmd_q   <= CMD_START_SORT;
                        data_q  <= '0;
                    end else if (transfer) begin
                        // Each accepted center restarts the idle-gap timer.
                        cmd_q    <= CMD_FILL;
                        data_q   <= center_data;
                        loaded_q <= loaded_d;
                        phase_q  <= '0;
                    end else if (phase_expired) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                S_SORT_START: begin
                    if (cmd_from_root == CMD_VALID_SORT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_SORT_WAIT;
                        phase_q <= '0;
                    end
                end
                S_SORT_WAIT: begin
                    if (cmd_from_root == CMD_VALID_SORT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (phase_expired) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Scoreboard bench for kd_tree_ctrl: a scripted tree/center-source model issues
// stimulus and queues expected root traffic; a monitor checks what the DUT emits.
`timescale 1ns/1ps
module tb_kd_tree_ctrl;

    localparam int CS = 5;
    localparam int DS = 24;
    localparam int TO = 16;
    localparam int CW = 16;

    localparam logic [4:0] NOP      = 5'h00;
    localparam logic [4:0] RST      = 5'h1f;
    localparam logic [4:0] RST_DONE = 5'h1e;
    localparam logic [4:0] CF       = 5'h01;
    localparam logic [4:0] CF_DONE  = 5'h05;
    localparam logic [4:0] SS       = 5'h09;
    localparam logic [4:0] VS       = 5'h0f;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          center_valid = 1'b0;
    logic [DS-1:0] center_data = '0;
    logic [CS-1:0] cmd_from_root = NOP;
    logic          busy, done, error, center_ready;
    logic [CS-1:0] cmd_to_root;
    logic [DS-1:0] data_to_root;
    logic [CW-1:0] centers_loaded;

    kd_tree_ctrl #(
        .COMMAND_SIZE(CS), .DATA_SIZE(DS), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .center_valid(center_valid), .center_data(center_data), .center_ready(center_ready),
        .cmd_to_root(cmd_to_root), .data_to_root(data_to_root), .cmd_from_root(cmd_from_root),
        .centers_loaded(centers_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] cmd; logic [23:0] data; } cmd_t;
    typedef struct packed { logic is_err; logic [15:0] n; } end_t;
    cmd_t cmd_q[$];
    end_t end_q[$];
    logic [DS-1:0] ctr [0:15];

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic next();
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a command, done or a new error.
    bit         mon_en = 1'b0;
    logic [4:0] prev_cmd = NOP;
    logic [23:0] prev_data = '0;
    logic       prev_err = 1'b0;
    cmd_t       ec;
    end_t       ee;
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (cmd_to_root !== NOP) begin
                if (cmd_q.size() == 0) chk("cmd_unexpected", cmd_to_root, NOP);
                else begin
                    ec = cmd_q.pop_front();
                    chk("cmd", cmd_to_root, ec.cmd);
                    chk("data", data_to_root, ec.data);
                end
            end else if (busy && prev_cmd == CF) begin
                chk("data_hold", data_to_root, prev_data);
            end
            if (done === 1'b1) begin
                if (end_q.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    ee = end_q.pop_front();
                    chk("error_at_done", error, ee.is_err);
                    chk("centers_at_done", centers_loaded, ee.n);
                end
            end
            if (error === 1'b1 && prev_err !== 1'b1) begin
                if (end_q.size() == 0) chk("error_unexpected", error, 0);
                else begin
                    ee = end_q.pop_front();
                    chk("error_kind", error, ee.is_err);
                    chk("done_at_error", done, 0);
                end
            end
            prev_cmd  = cmd_to_root;
            prev_data = data_to_root;
            prev_err  = error;
        end
    end

    // rst_lat==0 models a tree that never acknowledges reset.
    task automatic run_seq(input int rst_lat, input int n_ctr, input int vmode, input int sort_lat,
                           input bit coincide, input bit start_in_wait, input int abort_after,
                           input bit fill_hang);
        int sent;
        int idle;
        bit v;
        bit tog;
        for (int k = 0; k < ((rst_lat == 0) ? TO : rst_lat); k++) cmd_q.push_back({RST, 24'd0});
        start = 1'b1;
        next();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clr", error, 0);
        chk("start_loaded_clr", centers_loaded, 0);
        if (rst_lat == 0) begin
            end_q.push_back({1'b1, 16'd0});
            repeat (TO + 4) next();
            chk("rst_to_idle", busy, 0);
            chk("rst_to_sticky", error, 1);
            return;
        end
        for (int k = 1; k <= rst_lat; k++) begin
            cmd_from_root = (k == rst_lat) ? RST_DONE : NOP;
            next();
        end
        cmd_from_root = NOP;
        sent = 0;
        idle = 0;
        tog  = 1'b1;
        while (sent < n_ctr) begin
            case (vmode)
                0: v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 1) == 1) || (idle >= 3);
            endcase
            center_valid = v;
            center_data  = v ? ctr[sent] : DS'($urandom);
            if (v) begin
                cmd_q.push_back({CF, ctr[sent]});
                sent++;
                idle = 0;
            end else idle++;
            next();
            if (abort_after != 0 && sent == abort_after) begin
                center_valid = 1'b0;
                reset = 1'b1;
                next();
                reset = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_cmd", cmd_to_root, NOP);
                chk("abort_data", data_to_root, 0);
                chk("abort_loaded", centers_loaded, 0);
                chk("abort_ready", center_ready, 0);
                chk("abort_error", error, 0);
                return;
            end
        end
        center_valid = 1'b0;
        if (fill_hang) begin
            end_q.push_back({1'b1, 16'(n_ctr)});
            repeat (TO + 6) next();
            chk("fill_to_idle", busy, 0);
            chk("fill_to_sticky", error, 1);
            chk("fill_to_loaded", centers_loaded, n_ctr);
            return;
        end
        center_valid  = coincide;
        center_data   = DS'($urandom);
        cmd_from_root = CF_DONE;
        cmd_q.push_back({SS, 24'd0});
        end_q.push_back({1'b0, 16'(n_ctr)});
        next();
        center_valid  = 1'b0;
        cmd_from_root = (sort_lat == 0) ? VS : NOP;
        for (int j = 1; j <= sort_lat; j++) begin
            next();
            start = start_in_wait && (j == 1) && (sort_lat >= 2);
            cmd_from_root = (j == sort_lat) ? VS : NOP;
        end
        next();
        cmd_from_root = NOP;
        start = 1'b0;
        repeat (3) next();
        chk("run_idle", busy, 0);
        chk("run_error", error, 0);
        chk("run_loaded", centers_loaded, n_ctr);
    endtask

    initial begin
        repeat (3) next();
        chk("rst_cmd", cmd_to_root, NOP);
        chk("rst_data", data_to_root, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_loaded", centers_loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", center_ready, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        next();

        for (int i = 0; i < 7; i++) ctr[i] = 24'h0A0B0C + 24'(i) * 24'h010101;
        run_seq(3, 7, 0, 5, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 5; i++) ctr[i] = DS'($urandom);
        run_seq(2, 5, 1, 3, 1'b0, 1'b0, 0, 1'b0);

        run_seq(0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++) ctr[i] = DS'($urandom);
        run_seq(1, 4, 0, 0, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 3; i++) ctr[i] = DS'($urandom);
        run_seq(2, 3, 0, 4, 1'b0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 6; i++) ctr[i] = DS'($urandom);
        run_seq(2, 6, 0, 2, 1'b0, 1'b0, 3, 1'b0);
        next();

        for (int i = 0; i < 2; i++) ctr[i] = DS'($urandom);
        run_seq(1, 2, 0, 1, 1'b0, 1'b0, 0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) ctr[i] = DS'($urandom);
            run_seq($urandom_range(1, 6), n, 2, $urandom_range(0, 8),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        repeat (4) next();
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("end_queue_drained", end_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/kd_tree_ctrl.md
KD_TREE_CTRL -- requirements
Module: kd_tree_ctrl

Interface
REQ-001 SHALL have parameter COMMAND_SIZE, default 5, width of the tree command bus.
REQ-002 SHALL have parameter DATA_SIZE, default 24, width of the center/pixel data bus.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles per phase before error.
REQ-004 SHALL have parameter CNT_W, default 16, width of the center counter and timeout counter.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  host request to run one reset/fill/sort sequence; sampled only in IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on successful sort completion.
REQ-010 error  output  1  sticky phase-timeout flag, cleared by reset or by the next accepted start.
REQ-011 center_valid  input  1  center source has data.
REQ-012 center_data  input  DATA_SIZE  center value (RGB).
REQ-013 center_ready  output  1  combinational accept; transfer occurs when center_valid && center_ready.
REQ-014 cmd_to_root  output  COMMAND_SIZE  registered command to the root node's top port.
REQ-015 data_to_root  output  DATA_SIZE  registered data to the root node's top port.
REQ-016 cmd_from_root  input  COMMAND_SIZE  status command from the root node's top port.
REQ-017 centers_loaded  output  CNT_W  number of centers transferred in the current/last run.

Function
REQ-018 SHALL use command codes: nop 5'h00, rst 5'h1f, rst_done 5'h1e, center_fill 5'h01, center_fill_done 5'h05, start_sorting 5'h09, valid_sort 5'h0f.
REQ-019 SHALL implement states IDLE, TREE_RST, FILL, SORT_START, SORT_WAIT, DONE, ERR.
REQ-020 IDLE: cmd_to_root=nop, data_to_root=0; on start=1 SHALL go to TREE_RST, clear error, centers_loaded and the phase counter.
REQ-021 TREE_RST: SHALL drive rst each cycle; on cmd_from_root==rst_done SHALL go to FILL next cycle.
REQ-022 FILL: center_ready SHALL equal (state==FILL && cmd_from_root!=center_fill_done).
REQ-023 FILL: on a transfer SHALL register cmd_to_root=center_fill, data_to_root=center_data, increment centers_loaded (saturating at all-ones).
REQ-024 FILL: on a cycle without a transfer SHALL register cmd_to_root=nop and hold data_to_root.
REQ-025 FILL: on cmd_from_root==center_fill_done SHALL accept no data that cycle and go to SORT_START.
REQ-026 SORT_START: SHALL drive start_sorting with data_to_root=0 for exactly one cycle, then go to SORT_WAIT.
REQ-027 SORT_START: if cmd_from_root==valid_sort in that cycle SHALL go directly to DONE.
REQ-028 SORT_WAIT: SHALL drive nop; on cmd_from_root==valid_sort SHALL go to DONE.
REQ-029 DONE: SHALL drive nop, assert done for one cycle, then return to IDLE.
REQ-030 Phase counter SHALL clear on each entry to TREE_RST, FILL or SORT_WAIT and increment every cycle in those states.
REQ-031 Phase counter SHALL reset on each FILL transfer, so the FILL timeout measures idle gaps.
REQ-032 When the phase counter reaches TIMEOUT-1 without the exit condition SHALL go to ERR and set error.
REQ-033 ERR: SHALL drive nop for one cycle, then go to IDLE with error held.
REQ-034 The exit condition SHALL take priority over timeout when both occur in the same cycle.
REQ-035 start while busy SHALL be ignored.
REQ-036 Unknown cmd_from_root codes SHALL be ignored in every state.

Reset
REQ-037 On reset=1 at a rising edge, in any state including mid-fill or mid-sort, SHALL enter IDLE.
REQ-038 Reset SHALL force cmd_to_root=nop, data_to_root=0, done=0, error=0, centers_loaded=0 and phase counter=0.
REQ-039 center_ready SHALL be 0 while in IDLE.

Verification
REQ-040 Nominal run: start pulse; tree model returns rst_done after 3 cycles, accepts 7 centers 0x0A0B0C..0x101112 then center_fill_done, valid_sort 5 cycles after start_sorting -> cmd sequence rst x3, center_fill x7 with matching data, start_sorting x1, nop; done pulses once; centers_loaded=7; error=0.
REQ-041 Back-pressure: center_valid toggles 1,0,1,0 -> center_fill only on valid cycles, nop in gaps, data_to_root holds last value across gaps, no center lost or duplicated.
REQ-042 Timeout: TIMEOUT=16, tree never returns rst_done -> ERR entered after 16 TREE_RST cycles, error=1, done never pulses; next start clears error.
REQ-043 Reset mid-fill: reset asserted after 3 transfers -> next cycle IDLE, cmd_to_root=nop, centers_loaded=0, center_ready=0.
REQ-044 Corner cases: valid_sort during SORT_START goes straight to DONE; start asserted during SORT_WAIT is ignored; fill_done coincident with center_valid accepts no data.
